// File: rtl/rs_sched_pkg.sv
// Shared types and helpers for the reservation-station issue scheduler.
package rs_sched_pkg;

    // Scheduler FSM: either nothing is offered, or one slot/FU pairing is held.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_e;

    localparam int DEF_NUM_SLOTS = 8;
    localparam int DEF_NUM_FU    = 4;

    // Widest one-hot vector the index encoder handles.
    localparam int MAX_ONEHOT_W = 64;
    localparam int MAX_IDX_W    = 6;

    // Index width for a vector of n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Encode a one-hot (or all-zero) vector into its bit index.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_ONEHOT_W-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_ONEHOT_W; k++) begin
            if (oh[k]) begin
                idx = idx | MAX_IDX_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix over the reservation slots: tracks which busy slots were
// allocated before which, and reports the oldest slot in a candidate mask.
module rs_age_matrix
    import rs_sched_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] alloc_i,
    input  logic [NUM_SLOTS-1:0] clear_i,
    input  logic [NUM_SLOTS-1:0] cand_i,
    output logic [NUM_SLOTS-1:0] busy_o,
    output logic [NUM_SLOTS-1:0] oldest_o,
    output logic                 any_valid_o
);

    logic [NUM_SLOTS-1:0] busy_q;

    // Busy bit per slot: set by allocation, dropped by the issue clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clear_i) | alloc_i;
        end
    end

    assign busy_o = busy_q;

    genvar gi;
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_row
        // Bit j set: slot j was allocated before slot gi.
        logic [NUM_SLOTS-1:0] older_q;

        // Row gi is loaded with everything still busy (minus a slot issuing this
        // same edge); any newly allocated slot is wiped from the column so stale
        // history from its previous occupant never looks older.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                older_q <= '0;
            end else if (alloc_i[gi]) begin
                older_q <= busy_q & ~clear_i;
            end else begin
                older_q <= older_q & ~alloc_i;
            end
        end

        // Oldest: a candidate with no older candidate.
        assign oldest_o[gi] = cand_i[gi] & ~|(older_q & cand_i);
    end

    assign any_valid_o = |cand_i;

endmodule

// File: rtl/rs_issue_scheduler.sv
// Age-ordered, handshaked issue scheduler: offers the oldest ready slot on a
// round-robin free FU, holds the offer until accepted, then pulses slot_clear.
module rs_issue_scheduler
    import rs_sched_pkg::*;
#(
    parameter  int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter  int NUM_FU    = DEF_NUM_FU,
    parameter  int CNT_WIDTH = 16,
    localparam int SW        = idx_w(NUM_SLOTS),
    localparam int FW        = idx_w(NUM_FU)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] slot_alloc_i,
    input  logic [NUM_SLOTS-1:0] slot_ready_i,
    input  logic [NUM_FU-1:0]    fu_ready_i,
    input  logic                 flush_i,
    output logic                 issue_valid_o,
    output logic [SW-1:0]        slot_sel_o,
    output logic [FW-1:0]        fu_sel_o,
    output logic [NUM_SLOTS-1:0] slot_clear_o,
    output logic [CNT_WIDTH-1:0] issue_count_o
);

    sched_state_e         state_q;
    logic [SW-1:0]        slot_sel_q;
    logic [FW-1:0]        fu_sel_q;
    logic [FW-1:0]        rr_q;
    logic [FW-1:0]        rr_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [NUM_SLOTS-1:0] busy;
    logic [NUM_SLOTS-1:0] pending;
    logic [NUM_SLOTS-1:0] cand;
    logic [NUM_SLOTS-1:0] oldest;
    logic [SW-1:0]        oldest_idx;
    logic                 any_cand;
    logic                 take;
    logic                 idle_found;
    logic [FW-1:0]        idle_idx;
    logic                 reload_found;
    logic [FW-1:0]        reload_idx;

    // First set bit of mask at or after start, wrapping; MSB of result = found.
    function automatic logic [FW:0] rr_pick(input logic [NUM_FU-1:0] mask, input logic [FW-1:0] start);
        logic [2*NUM_FU-1:0] dbl;
        logic [NUM_FU-1:0]   rot;
        logic [FW:0]         res;
        int                  c;
        dbl = {mask, mask} >> start;
        rot = dbl[NUM_FU-1:0];
        res = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (rot[k]) begin
                c = int'(start) + k;
                if (c >= NUM_FU) begin
                    c = c - NUM_FU;
                end
                res = {1'b1, FW'(c)};
            end
        end
        return res;
    endfunction

    assign issue_valid_o = (state_q == OFFER);
    assign slot_sel_o    = slot_sel_q;
    assign fu_sel_o      = fu_sel_q;
    assign issue_count_o = cnt_q;

    // The offered slot is excluded from selection so a reload picks a different one.
    assign pending      = issue_valid_o ? (NUM_SLOTS'(1) << slot_sel_q) : '0;
    assign cand         = slot_ready_i & busy & ~pending;
    assign take         = issue_valid_o & fu_ready_i[fu_sel_q] & ~flush_i;
    assign slot_clear_o = take ? pending : '0;
    assign rr_d         = (fu_sel_q == FW'(NUM_FU - 1)) ? '0 : fu_sel_q + 1'b1;
    assign oldest_idx   = SW'(onehot_to_idx(MAX_ONEHOT_W'(oldest)));

    assign {idle_found, idle_idx}     = rr_pick(fu_ready_i, rr_q);
    assign {reload_found, reload_idx} = rr_pick(fu_ready_i & ~(NUM_FU'(1) << fu_sel_q), rr_d);

    rs_age_matrix #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_age (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_i     (slot_alloc_i),
        .clear_i     (slot_clear_o),
        .cand_i      (cand),
        .busy_o      (busy),
        .oldest_o    (oldest),
        .any_valid_o (any_cand)
    );

    // Offer FSM with round-robin pointer and accepted-issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            slot_sel_q <= '0;
            fu_sel_q   <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            if (take) begin
                cnt_q <= cnt_q + 1'b1;
                rr_q  <= rr_d;
            end
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (any_cand && idle_found) begin
                            state_q    <= OFFER;
                            slot_sel_q <= oldest_idx;
                            fu_sel_q   <= idle_idx;
                        end
                    end
                    OFFER: begin
                        if (take) begin
                            if (any_cand && reload_found) begin
                                slot_sel_q <= oldest_idx;
                                fu_sel_q   <= reload_idx;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (idle_found) begin
                            // Offered FU went away: keep the slot, move to another free FU.
                            fu_sel_q <= idle_idx;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Allocation must target a single free slot.
    alloc_legal: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(slot_alloc_i) && ((slot_alloc_i & busy) == '0));

endmodule
